// File: rtl/arch_defs_pkg.sv
// Shared architectural definitions for the register-file load/increment/decrement unit.
// Holds the operation and FSM state encodings and the default data width.
package arch_defs_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_NOP  = 2'd3
  } incdec_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } incdec_state_t;

endpackage

// File: rtl/incdec_alu.sv
// Combinational incrementer/decrementer over DATA_WIDTH+1 bits.
// The top bit of o_result is the INC carry-out or the DEC borrow.
module incdec_alu
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_operand,
  output logic [DATA_WIDTH:0]   o_result,
  output logic                  o_zero,
  output logic                  o_negative,
  output logic                  o_carry
);

  logic [DATA_WIDTH:0] w_ext;

  always_comb begin
    w_ext    = {1'b0, i_operand};
    o_result = w_ext;
    case (incdec_op_t'(i_op))
      OP_INC:  o_result = w_ext + (DATA_WIDTH+1)'(1);
      // 0 - 1 sets the extra bit, which doubles as the borrow.
      OP_DEC:  o_result = w_ext - (DATA_WIDTH+1)'(1);
      default: o_result = w_ext;
    endcase
  end

  assign o_zero     = (o_result[DATA_WIDTH-1:0] == '0);
  assign o_negative = o_result[DATA_WIDTH-1];
  assign o_carry    = o_result[DATA_WIDTH];

endmodule

// File: rtl/regfile_incdec_unit.sv
// Register-file execution unit for LOAD/INC/DEC with start/done handshake,
// Z/N/C flags and out-of-range select detection.
//
//   state   | meaning
//   S_IDLE  | waiting for start_i; latches op/sel/load_data on start
//   S_FETCH | operand <- regs[sel], or load_data for LOAD
//   S_EXEC  | ALU result and flag candidates registered
//   S_WRITE | register and flags commit; done_o/err_o pulse next cycle
module regfile_incdec_unit
  import arch_defs_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_REGS   = 4,
  parameter int SEL_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [SEL_WIDTH-1:0]  sel_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  input  logic [SEL_WIDTH-1:0]  rd_sel_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  flag_zero_o,
  output logic                  flag_negative_o,
  output logic                  flag_carry_o
);

  incdec_state_t         r_state, w_state_next;
  incdec_op_t            r_op;
  logic [SEL_WIDTH-1:0]  r_sel;
  logic [DATA_WIDTH-1:0] r_load;
  logic [DATA_WIDTH-1:0] r_temp;
  logic [DATA_WIDTH:0]   r_res;
  logic                  r_res_zero, r_res_neg;
  logic                  r_flag_z, r_flag_n, r_flag_c;
  logic                  r_done, r_err;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [DATA_WIDTH-1:0] w_fetch, w_rd;
  logic [DATA_WIDTH:0]   w_alu_result;
  logic                  w_alu_zero, w_alu_neg, w_alu_carry;
  logic                  w_sel_ok, w_commit;

  incdec_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_op       (r_op),
    .i_operand  (r_temp),
    .o_result   (w_alu_result),
    .o_zero     (w_alu_zero),
    .o_negative (w_alu_neg),
    .o_carry    (w_alu_carry)
  );

  assign w_sel_ok = (int'(r_sel) < NUM_REGS);
  assign w_commit = w_sel_ok && (r_op != OP_NOP);

  // Loop-based muxes keep non-power-of-2 register counts safe: out-of-range reads give 0.
  always_comb begin
    w_fetch = '0;
    w_rd    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (SEL_WIDTH'(i) == r_sel)    w_fetch = r_regs[i];
      if (SEL_WIDTH'(i) == rd_sel_i) w_rd    = r_regs[i];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_WRITE;
      S_WRITE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_sel      <= '0;
      r_load     <= '0;
      r_temp     <= '0;
      r_res      <= '0;
      r_res_zero <= 1'b0;
      r_res_neg  <= 1'b0;
      r_flag_z   <= 1'b0;
      r_flag_n   <= 1'b0;
      r_flag_c   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_op   <= incdec_op_t'(op_i);
            r_sel  <= sel_i;
            r_load <= load_data_i;
          end
        end
        S_FETCH: r_temp <= (r_op == OP_LOAD) ? r_load : w_fetch;
        S_EXEC: begin
          r_res      <= w_alu_result;
          r_res_zero <= w_alu_zero;
          r_res_neg  <= w_alu_neg;
        end
        S_WRITE: begin
          r_done <= 1'b1;
          r_err  <= !w_sel_ok;
          if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (SEL_WIDTH'(i) == r_sel) r_regs[i] <= r_res[DATA_WIDTH-1:0];
            r_flag_z <= r_res_zero;
            r_flag_n <= r_res_neg;
            if (r_op != OP_LOAD) r_flag_c <= r_res[DATA_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o          = (r_state != S_IDLE);
  assign done_o          = r_done;
  assign err_o           = r_err;
  assign rd_data_o       = w_rd;
  assign flag_zero_o     = r_flag_z;
  assign flag_negative_o = r_flag_n;
  assign flag_carry_o    = r_flag_c;

  // The carry output of the ALU is folded into r_res; keep it observable for clarity.
  logic w_unused_carry;
  assign w_unused_carry = w_alu_carry;

endmodule

// File: tb/tb_regfile_incdec_unit.sv
// Directed bench for regfile_incdec_unit: a default 8-bit/4-register instance (A)
// and a 16-bit/3-register instance (B) for out-of-range select and wide data.
module tb_regfile_incdec_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic       a_start = 0;
  logic [1:0] a_op = 0;
  logic [1:0] a_sel = 0;
  logic [7:0] a_data = 0;
  logic [1:0] a_rd_sel = 0;
  logic       a_busy, a_done, a_err, a_z, a_n, a_c;
  logic [7:0] a_rd;

  logic        b_start = 0;
  logic [1:0]  b_op = 0;
  logic [1:0]  b_sel = 0;
  logic [15:0] b_data = 0;
  logic [1:0]  b_rd_sel = 0;
  logic        b_busy, b_done, b_err, b_z, b_n, b_c;
  logic [15:0] b_rd;

  regfile_incdec_unit dut_a (
    .clk(clk), .reset(reset), .start_i(a_start), .op_i(a_op), .sel_i(a_sel),
    .load_data_i(a_data), .busy_o(a_busy), .done_o(a_done), .err_o(a_err),
    .rd_sel_i(a_rd_sel), .rd_data_o(a_rd), .flag_zero_o(a_z),
    .flag_negative_o(a_n), .flag_carry_o(a_c)
  );

  regfile_incdec_unit #(.DATA_WIDTH(16), .NUM_REGS(3)) dut_b (
    .clk(clk), .reset(reset), .start_i(b_start), .op_i(b_op), .sel_i(b_sel),
    .load_data_i(b_data), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
    .rd_sel_i(b_rd_sel), .rd_data_o(b_rd), .flag_zero_o(b_z),
    .flag_negative_o(b_n), .flag_carry_o(b_c)
  );

  localparam logic [1:0] LOAD = 2'd0, INC = 2'd1, DEC = 2'd2;

  // Issue one op on A and observe six falling edges starting right after the accept edge.
  task automatic run_a(input logic [1:0] op, input logic [1:0] sel, input logic [7:0] data,
                       output int done_at, output int busy_cnt, output int done_cnt,
                       output int err_cnt);
    @(negedge clk);
    a_start = 1; a_op = op; a_sel = sel; a_data = data;
    @(negedge clk);
    a_start = 0;
    done_at = -1; busy_cnt = 0; done_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_busy) busy_cnt++;
      if (a_done) begin done_cnt++; if (done_at < 0) done_at = k; end
      if (a_err) err_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic run_b(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] data,
                       output int done_at, output int err_at);
    @(negedge clk);
    b_start = 1; b_op = op; b_sel = sel; b_data = data;
    @(negedge clk);
    b_start = 0;
    done_at = -1; err_at = -1;
    for (int k = 0; k < 6; k++) begin
      if (b_done && done_at < 0) done_at = k;
      if (b_err && err_at < 0) err_at = k;
      @(negedge clk);
    end
  endtask

  task automatic read_a(input logic [1:0] sel, output logic [7:0] val);
    a_rd_sel = sel; #1; val = a_rd;
  endtask

  task automatic read_b(input logic [1:0] sel, output logic [15:0] val);
    b_rd_sel = sel; #1; val = b_rd;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    logic [15:0] w;
    n_cmp++; if ({a_busy, a_done, a_err} !== 3'b000) begin n_err++;
      $display("FAIL reset_ctrl_a: got %b want 000", {a_busy, a_done, a_err}); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b000) begin n_err++;
      $display("FAIL reset_flags_a: got %b want 000", {a_z, a_n, a_c}); end
    for (int i = 0; i < 4; i++) begin
      read_a(2'(i), v);
      n_cmp++; if (v !== 8'h00) begin n_err++;
        $display("FAIL reset_reg_a r%0d: got %h want 00", i, v); end
    end
    n_cmp++; if ({b_busy, b_done, b_err, b_z, b_n, b_c} !== 6'b0) begin n_err++;
      $display("FAIL reset_b: got %b want 000000", {b_busy, b_done, b_err, b_z, b_n, b_c}); end
    read_b(2'd2, w);
    n_cmp++; if (w !== 16'h0) begin n_err++;
      $display("FAIL reset_reg_b r2: got %h want 0000", w); end
  endtask

  task automatic test_load_inc;
    int da, bc, dc, ec;
    logic [7:0] v;
    run_a(LOAD, 2'd1, 8'h01, da, bc, dc, ec);
    n_cmp++; if (da !== 3) begin n_err++; $display("FAIL load_done_cycle: got %0d want 3", da); end
    n_cmp++; if (bc !== 3) begin n_err++; $display("FAIL load_busy_cycles: got %0d want 3", bc); end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL load_done_count: got %0d want 1", dc); end
    n_cmp++; if (ec !== 0) begin n_err++; $display("FAIL load_err: got %0d want 0", ec); end
    run_a(INC, 2'd1, 8'h00, da, bc, dc, ec);
    n_cmp++; if (da !== 3 || bc !== 3) begin n_err++;
      $display("FAIL inc_timing: got done_at=%0d busy=%0d want 3/3", da, bc); end
    read_a(2'd1, v);
    n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL inc_r1: got %h want 02", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b000) begin n_err++;
      $display("FAIL inc_flags: got ZNC=%b want 000", {a_z, a_n, a_c}); end
  endtask

  task automatic test_inc_wrap;
    int da, bc, dc, ec;
    logic [7:0] v;
    run_a(LOAD, 2'd2, 8'hFF, da, bc, dc, ec);
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b010) begin n_err++;
      $display("FAIL load_ff_flags: got ZNC=%b want 010", {a_z, a_n, a_c}); end
    run_a(INC, 2'd2, 8'h00, da, bc, dc, ec);
    read_a(2'd2, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL incwrap_r2: got %h want 00", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b101) begin n_err++;
      $display("FAIL incwrap_flags: got ZNC=%b want 101", {a_z, a_n, a_c}); end
    run_a(LOAD, 2'd2, 8'h05, da, bc, dc, ec);
    read_a(2'd2, v);
    n_cmp++; if (v !== 8'h05) begin n_err++; $display("FAIL load5_r2: got %h want 05", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b001) begin n_err++;
      $display("FAIL load_keeps_c: got ZNC=%b want 001", {a_z, a_n, a_c}); end
  endtask

  task automatic test_dec_wrap;
    int da, bc, dc, ec;
    logic [7:0] v;
    run_a(LOAD, 2'd0, 8'h00, da, bc, dc, ec);
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b101) begin n_err++;
      $display("FAIL load0_flags: got ZNC=%b want 101", {a_z, a_n, a_c}); end
    run_a(DEC, 2'd0, 8'h00, da, bc, dc, ec);
    read_a(2'd0, v);
    n_cmp++; if (v !== 8'hFF) begin n_err++; $display("FAIL decwrap_r0: got %h want ff", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b011) begin n_err++;
      $display("FAIL decwrap_flags: got ZNC=%b want 011", {a_z, a_n, a_c}); end
    run_a(DEC, 2'd0, 8'h00, da, bc, dc, ec);
    read_a(2'd0, v);
    n_cmp++; if (v !== 8'hFE) begin n_err++; $display("FAIL dec2_r0: got %h want fe", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b010) begin n_err++;
      $display("FAIL dec2_flags: got ZNC=%b want 010", {a_z, a_n, a_c}); end
    read_a(2'd1, v);
    n_cmp++; if (v !== 8'h02) begin n_err++; $display("FAIL dec_r1_kept: got %h want 02", v); end
    read_a(2'd2, v);
    n_cmp++; if (v !== 8'h05) begin n_err++; $display("FAIL dec_r2_kept: got %h want 05", v); end
    read_a(2'd3, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL dec_r3_kept: got %h want 00", v); end
  endtask

  task automatic test_busy_ignore;
    int dc;
    logic [7:0] v;
    @(negedge clk);
    a_start = 1; a_op = INC; a_sel = 2'd3; a_data = 8'h00;
    @(negedge clk);
    a_start = 1;
    @(negedge clk);
    a_start = 0;
    dc = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_done) dc++;
      @(negedge clk);
    end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL busy_ignore_dones: got %0d want 1", dc); end
    read_a(2'd3, v);
    n_cmp++; if (v !== 8'h01) begin n_err++; $display("FAIL busy_ignore_r3: got %h want 01", v); end
  endtask

  task automatic test_back_to_back;
    int waited, da;
    logic [7:0] mid, fin;
    a_rd_sel = 2'd3;
    @(negedge clk);
    a_start = 1; a_op = INC; a_sel = 2'd3;
    @(negedge clk);
    a_start = 0;
    waited = 0;
    while (!a_done && waited < 8) begin @(negedge clk); waited++; end
    n_cmp++; if (!a_done) begin n_err++; $display("FAIL b2b_first_done: got 0 want 1 (timeout)"); end
    #1;
    n_cmp++; if (a_rd !== 8'h02) begin n_err++; $display("FAIL b2b_first_r3: got %h want 02", a_rd); end
    a_start = 1; a_op = INC; a_sel = 2'd3;
    @(negedge clk);
    a_start = 0;
    da = -1; mid = 8'hxx; fin = 8'hxx;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k == 2) mid = a_rd;
      if (a_done && da < 0) begin da = k; fin = a_rd; end
      @(negedge clk);
    end
    n_cmp++; if (da !== 3) begin n_err++; $display("FAIL b2b_second_done: got %0d want 3", da); end
    n_cmp++; if (mid !== 8'h02) begin n_err++; $display("FAIL b2b_no_bypass: got %h want 02", mid); end
    n_cmp++; if (fin !== 8'h03) begin n_err++; $display("FAIL b2b_second_r3: got %h want 03", fin); end
  endtask

  task automatic test_reset_mid;
    int da, bc, dc, ec, busy_seen;
    logic [7:0] v;
    run_a(LOAD, 2'd1, 8'h10, da, bc, dc, ec);
    read_a(2'd1, v);
    n_cmp++; if (v !== 8'h10) begin n_err++; $display("FAIL pre_reset_r1: got %h want 10", v); end
    @(negedge clk);
    a_start = 1; a_op = INC; a_sel = 2'd1;
    @(negedge clk);
    a_start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    dc = 0; busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_done) dc++;
      if (a_busy) busy_seen++;
      @(negedge clk);
    end
    n_cmp++; if (dc !== 0 || busy_seen !== 0) begin n_err++;
      $display("FAIL reset_mid_ctrl: got done=%0d busy=%0d want 0/0", dc, busy_seen); end
    read_a(2'd1, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_mid_r1: got %h want 00", v); end
    n_cmp++; if ({a_z, a_n, a_c} !== 3'b000) begin n_err++;
      $display("FAIL reset_mid_flags: got ZNC=%b want 000", {a_z, a_n, a_c}); end
  endtask

  task automatic test_wide_and_range;
    int da, ea;
    logic [15:0] w;
    run_b(LOAD, 2'd2, 16'h7FFF, da, ea);
    run_b(INC, 2'd2, 16'h0000, da, ea);
    n_cmp++; if (da !== 3 || ea !== -1) begin n_err++;
      $display("FAIL wide_inc_ctrl: got done_at=%0d err_at=%0d want 3/-1", da, ea); end
    read_b(2'd2, w);
    n_cmp++; if (w !== 16'h8000) begin n_err++; $display("FAIL wide_inc_r2: got %h want 8000", w); end
    n_cmp++; if ({b_z, b_n, b_c} !== 3'b010) begin n_err++;
      $display("FAIL wide_inc_flags: got ZNC=%b want 010", {b_z, b_n, b_c}); end
    run_b(INC, 2'd3, 16'h0000, da, ea);
    n_cmp++; if (da !== 3 || ea !== 3) begin n_err++;
      $display("FAIL oor_pulse: got done_at=%0d err_at=%0d want 3/3", da, ea); end
    n_cmp++; if ({b_z, b_n, b_c} !== 3'b010) begin n_err++;
      $display("FAIL oor_flags: got ZNC=%b want 010", {b_z, b_n, b_c}); end
    read_b(2'd0, w);
    n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL oor_r0: got %h want 0000", w); end
    read_b(2'd1, w);
    n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL oor_r1: got %h want 0000", w); end
    read_b(2'd2, w);
    n_cmp++; if (w !== 16'h8000) begin n_err++; $display("FAIL oor_r2: got %h want 8000", w); end
    read_b(2'd3, w);
    n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL oor_read: got %h want 0000", w); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    test_reset();
    test_load_inc();
    test_inc_wrap();
    test_dec_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_wide_and_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
